// File: rtl/pc_context_unit.sv
// Multi-context program-counter unit for the fetch stage.
// Round-robin selection of running contexts with per-context redirect, halt and start.
module pc_context_unit #(
    parameter int               WIDTH   = 32,
    parameter int               NUM_CTX = 4,
    parameter logic [WIDTH-1:0] PC_INIT = '0,
    parameter logic [WIDTH-1:0] PC_STEP = WIDTH'(4),
    localparam int              CW      = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               fetch_ready,
    output logic               fetch_valid,
    output logic [CW-1:0]      fetch_ctx,
    output logic [WIDTH-1:0]   fetch_pc,
    input  logic               redirect_en,
    input  logic [CW-1:0]      redirect_ctx,
    input  logic [WIDTH-1:0]   redirect_pc,
    input  logic               halt_en,
    input  logic [CW-1:0]      halt_ctx,
    input  logic               start_en,
    input  logic [CW-1:0]      start_ctx,
    input  logic [WIDTH-1:0]   start_pc,
    output logic [NUM_CTX-1:0] ctx_running,
    output logic               all_halted
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } ctx_state_t;

    ctx_state_t       st_q [NUM_CTX];
    logic [WIDTH-1:0] pc_q [NUM_CTX];
    logic [CW-1:0]    rr_q;

    logic [NUM_CTX-1:0] run_vec;
    logic [NUM_CTX-1:0] halt_hit;
    logic [NUM_CTX-1:0] redir_hit;
    logic [NUM_CTX-1:0] start_hit;
    logic [NUM_CTX-1:0] adv_hit;
    logic               sel_found;
    logic [CW-1:0]      sel_idx;
    logic               accept;
    logic [CW-1:0]      rr_next;

    // Decode which contexts are currently running
    always_comb begin
        run_vec = '0;
        for (int i = 0; i < NUM_CTX; i++) begin
            run_vec[i] = (st_q[i] == RUN);
        end
    end

    // First running context at or after rr, then wrap around below rr
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int j = 0; j < NUM_CTX; j++) begin
            if (!sel_found && run_vec[j] && (j >= int'(rr_q))) begin
                sel_found = 1'b1;
                sel_idx   = CW'(j);
            end
        end
        for (int j = 0; j < NUM_CTX; j++) begin
            if (!sel_found && run_vec[j] && (j < int'(rr_q))) begin
                sel_found = 1'b1;
                sel_idx   = CW'(j);
            end
        end
    end

    assign accept  = sel_found & fetch_ready;
    assign rr_next = (int'(sel_idx) == NUM_CTX - 1) ? '0 : sel_idx + CW'(1);

    // Per-context command hits; out-of-range indices never match
    always_comb begin
        halt_hit  = '0;
        redir_hit = '0;
        start_hit = '0;
        adv_hit   = '0;
        for (int i = 0; i < NUM_CTX; i++) begin
            halt_hit[i]  = halt_en     && (int'(halt_ctx)     == i);
            redir_hit[i] = redirect_en && (int'(redirect_ctx) == i);
            start_hit[i] = start_en    && (int'(start_ctx)    == i);
            adv_hit[i]   = accept      && (int'(sel_idx)      == i);
        end
    end

    // Context state, PC and round-robin pointer update
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NUM_CTX; i++) begin
                st_q[i] <= (i == 0) ? RUN : IDLE;
                pc_q[i] <= PC_INIT;
            end
            rr_q <= '0;
        end else begin
            if (accept) begin
                rr_q <= rr_next;
            end
            for (int i = 0; i < NUM_CTX; i++) begin
                unique case (st_q[i])
                    RUN: begin
                        if (halt_hit[i]) begin
                            st_q[i] <= HALTED;
                        end else if (redir_hit[i]) begin
                            pc_q[i] <= redirect_pc;
                        end else if (adv_hit[i]) begin
                            pc_q[i] <= pc_q[i] + PC_STEP;
                        end
                    end
                    IDLE, HALTED: begin
                        if (start_hit[i]) begin
                            st_q[i] <= RUN;
                            pc_q[i] <= start_pc;
                        end
                    end
                    default: begin
                        st_q[i] <= IDLE;
                    end
                endcase
            end
        end
    end

    assign fetch_valid = sel_found;
    assign fetch_ctx   = sel_idx;
    assign fetch_pc    = sel_found ? pc_q[sel_idx] : '0;
    assign ctx_running = run_vec;
    assign all_halted  = ~|run_vec;

endmodule

// File: tb/tb_pc_context_unit.sv
// Bench for pc_context_unit: behavioural model compared every cycle
// plus directed literal expectations on a 4-context and a narrow 3-context instance.
`timescale 1ns/1ps
module tb_pc_context_unit;

    logic        CLK;
    logic        nRST;

    logic        fetch_ready;
    logic        fetch_valid;
    logic [1:0]  fetch_ctx;
    logic [31:0] fetch_pc;
    logic        redirect_en;
    logic [1:0]  redirect_ctx;
    logic [31:0] redirect_pc;
    logic        halt_en;
    logic [1:0]  halt_ctx;
    logic        start_en;
    logic [1:0]  start_ctx;
    logic [31:0] start_pc;
    logic [3:0]  ctx_running;
    logic        all_halted;

    logic        rdy1;
    logic        v1;
    logic [1:0]  c1;
    logic [7:0]  pc1;
    logic        red1_en;
    logic [1:0]  red1_ctx;
    logic [7:0]  red1_pc;
    logic        h1_en;
    logic [1:0]  h1_ctx;
    logic        s1_en;
    logic [1:0]  s1_ctx;
    logic [7:0]  s1_pc;
    logic [2:0]  run1;
    logic        ah1;

    int checks = 0;
    int errors = 0;

    pc_context_unit #(.WIDTH(32), .NUM_CTX(4)) u0 (
        .CLK(CLK), .nRST(nRST),
        .fetch_ready(fetch_ready), .fetch_valid(fetch_valid),
        .fetch_ctx(fetch_ctx), .fetch_pc(fetch_pc),
        .redirect_en(redirect_en), .redirect_ctx(redirect_ctx),
        .redirect_pc(redirect_pc),
        .halt_en(halt_en), .halt_ctx(halt_ctx),
        .start_en(start_en), .start_ctx(start_ctx), .start_pc(start_pc),
        .ctx_running(ctx_running), .all_halted(all_halted)
    );

    pc_context_unit #(.WIDTH(8), .NUM_CTX(3), .PC_INIT(8'hFC)) u1 (
        .CLK(CLK), .nRST(nRST),
        .fetch_ready(rdy1), .fetch_valid(v1),
        .fetch_ctx(c1), .fetch_pc(pc1),
        .redirect_en(red1_en), .redirect_ctx(red1_ctx),
        .redirect_pc(red1_pc),
        .halt_en(h1_en), .halt_ctx(h1_ctx),
        .start_en(s1_en), .start_ctx(s1_ctx), .start_pc(s1_pc),
        .ctx_running(run1), .all_halted(ah1)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // ---------------- behavioural model of u0 ----------------
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    int          m_st [4];
    logic [31:0] m_pc [4];
    int          m_rr;
    bit          mv;
    int          mc;
    bit          macc;

    function automatic void m_sel(output bit v, output int c);
        v = 1'b0;
        c = 0;
        for (int k = 0; k < 4; k++) begin
            int j;
            j = (m_rr + k) % 4;
            if (!v && m_st[j] == M_RUN) begin
                v = 1'b1;
                c = j;
            end
        end
    endfunction

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < 4; i++) begin
                m_st[i] = (i == 0) ? M_RUN : M_IDLE;
                m_pc[i] = 32'h0;
            end
            m_rr = 0;
        end else begin
            m_sel(mv, mc);
            macc = mv && fetch_ready;
            for (int i = 0; i < 4; i++) begin
                if (m_st[i] == M_RUN) begin
                    if (halt_en && halt_ctx == i)
                        m_st[i] = M_HALT;
                    else if (redirect_en && redirect_ctx == i)
                        m_pc[i] = redirect_pc;
                    else if (macc && mc == i)
                        m_pc[i] = m_pc[i] + 32'd4;
                end else if (start_en && start_ctx == i) begin
                    m_st[i] = M_RUN;
                    m_pc[i] = start_pc;
                end
            end
            if (macc) m_rr = (mc + 1) % 4;
        end
    end

    bit          cv;
    int          cc;
    logic [3:0]  crun;
    logic [39:0] cexp;
    logic [39:0] cgot;

    always @(negedge CLK) begin
        m_sel(cv, cc);
        for (int i = 0; i < 4; i++) crun[i] = (m_st[i] == M_RUN);
        cexp = {cv, 2'(cc), cv ? m_pc[cc] : 32'h0, crun, ~|crun};
        cgot = {fetch_valid, fetch_ctx, fetch_pc, ctx_running, all_halted};
        checks++;
        if (cgot !== cexp) begin
            errors++;
            $display("FAIL model_cmp t=%0t got %h expected %h", $time, cgot, cexp);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic chk_fetch(input string nm, input logic v, input logic [1:0] c,
                             input logic [31:0] pc);
        chk(nm, {fetch_valid, fetch_ctx, fetch_pc}, {v, c, pc});
    endtask

    task automatic cyc(input bit rdy,
                       input bit se, input logic [1:0] sc, input logic [31:0] sp,
                       input bit he, input logic [1:0] hc,
                       input bit re, input logic [1:0] rc, input logic [31:0] rp);
        fetch_ready  = rdy;
        start_en     = se;
        start_ctx    = sc;
        start_pc     = sp;
        halt_en      = he;
        halt_ctx     = hc;
        redirect_en  = re;
        redirect_ctx = rc;
        redirect_pc  = rp;
        @(posedge CLK);
        #1;
        fetch_ready  = 1'b0;
        start_en     = 1'b0;
        halt_en      = 1'b0;
        redirect_en  = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        nRST = 1'b0;
        fetch_ready = 0; redirect_en = 0; redirect_ctx = 0; redirect_pc = 0;
        halt_en = 0; halt_ctx = 0; start_en = 0; start_ctx = 0; start_pc = 0;
        rdy1 = 0; red1_en = 0; red1_ctx = 0; red1_pc = 0;
        h1_en = 0; h1_ctx = 0; s1_en = 0; s1_ctx = 0; s1_pc = 0;
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;

        // reset state
        chk_fetch("reset_fetch", 1'b1, 2'd0, 32'h0);
        chk("reset_running", {ctx_running, all_halted}, {4'b0001, 1'b0});

        // sequential advance on ctx 0
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_fetch("adv_pc4", 1'b1, 2'd0, 32'h4);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_fetch("adv_pc8", 1'b1, 2'd0, 32'h8);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // start ctx 2 and alternate
        cyc(1, 1, 2, 32'h100, 0, 0, 0, 0, 0);
        chk_fetch("alt_ctx2_a", 1'b1, 2'd2, 32'h100);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_fetch("alt_ctx0", 1'b1, 2'd0, 32'h10);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_fetch("alt_ctx2_b", 1'b1, 2'd2, 32'h104);
        chk("alt_running", ctx_running, 4'b0101);

        // redirect beats increment on the accepted context
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 32'h40);
        chk_fetch("redir_other", 1'b1, 2'd2, 32'h108);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_fetch("redir_pc", 1'b1, 2'd0, 32'h40);

        // halt with accept, then restart
        cyc(0, 0, 0, 0, 1, 2, 0, 0, 0);
        chk("halt2_running", ctx_running, 4'b0001);
        cyc(1, 0, 0, 0, 1, 0, 0, 0, 0);
        chk_fetch("halt_fetch", 1'b0, 2'd0, 32'h0);
        chk("halt_all", {ctx_running, all_halted}, {4'b0000, 1'b1});
        cyc(1, 1, 0, 32'h200, 0, 0, 0, 0, 0);
        chk_fetch("restart_fetch", 1'b1, 2'd0, 32'h200);
        chk("sticky_halt", ctx_running, 4'b0001);

        // ignored commands: redirect idle ctx 3, start running ctx 0
        cyc(0, 0, 0, 0, 0, 0, 1, 3, 32'h999);
        cyc(0, 1, 0, 32'h500, 0, 0, 0, 0, 0);
        chk_fetch("ign_start_run", 1'b1, 2'd0, 32'h200);
        cyc(0, 1, 3, 32'h300, 0, 0, 0, 0, 0);
        chk_fetch("ign_redir_idle", 1'b1, 2'd3, 32'h300);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_fetch("rr_wrap", 1'b1, 2'd0, 32'h200);

        // narrow instance: PC wrap, stall stability, out-of-range indices
        chk("w8_reset", {v1, c1, pc1}, {1'b1, 2'd0, 8'hFC});
        rdy1 = 1'b1;
        @(posedge CLK); #1;
        rdy1 = 1'b0;
        chk("w8_wrap", {v1, c1, pc1}, {1'b1, 2'd0, 8'h00});
        red1_en = 1'b1; red1_ctx = 2'd3; red1_pc = 8'h55;
        h1_en = 1'b1; h1_ctx = 2'd3;
        s1_en = 1'b1; s1_ctx = 2'd3; s1_pc = 8'hAA;
        for (int k = 0; k < 5; k++) begin
            @(posedge CLK); #1;
            chk("w8_stable", {v1, c1, pc1, run1, ah1},
                {1'b1, 2'd0, 8'h00, 3'b001, 1'b0});
        end
        red1_en = 1'b0; h1_en = 1'b0; s1_en = 1'b0;

        // asynchronous reset mid-cycle with a redirect pending
        fetch_ready = 1'b1;
        redirect_en = 1'b1; redirect_ctx = 2'd0; redirect_pc = 32'h777;
        #3 nRST = 1'b0;
        #1;
        chk_fetch("async_rst_fetch", 1'b1, 2'd0, 32'h0);
        chk("async_rst_run", {ctx_running, all_halted}, {4'b0001, 1'b0});
        chk("async_rst_w8", pc1, 8'hFC);
        fetch_ready = 1'b0;
        redirect_en = 1'b0;
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
        chk_fetch("post_rst", 1'b1, 2'd0, 32'h0);

        // multi-context burst with simultaneous commands
        cyc(1, 1, 1, 32'h1000, 0, 0, 0, 0, 0);
        chk_fetch("b_start1", 1'b1, 2'd1, 32'h1000);
        cyc(1, 1, 3, 32'h3000, 0, 0, 1, 1, 32'h1800);
        chk_fetch("b_start3", 1'b1, 2'd3, 32'h3000);
        cyc(1, 0, 0, 0, 1, 1, 1, 3, 32'h3800);
        chk_fetch("b_halt1", 1'b1, 2'd0, 32'h4);
        chk("b_run_a", ctx_running, 4'b1001);
        cyc(1, 1, 1, 32'h1100, 0, 0, 0, 0, 0);
        chk_fetch("b_restart1", 1'b1, 2'd1, 32'h1100);
        cyc(0, 0, 0, 0, 1, 3, 0, 0, 0);
        chk("b_run_b", ctx_running, 4'b0011);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_fetch("b_final", 1'b1, 2'd0, 32'hC);

        repeat (2) @(posedge CLK);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
